myproject_mac_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle HLS multiplier cores.
- Operand widths and per-operand signedness are configurable; pipeline depth is configurable.
- Adds clock-enable stall, valid tracking, and an optional saturating accumulate mode.
- Instantiated by dense/conv kernels that need a registered product or a running dot-product sum.

---
 rtl/myproject_mac_pipe.sv | 186 ++++++++++++++++++
 tb/tb_myproject_mac_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/myproject_mac_pipe.sv
// myproject_mac_pipe: parametrised pipelined multiplier with optional
// saturating accumulate.
//
// The operands are registered in stage 1. Each operand is extended by one
// bit (sign or zero, chosen per operand) and the two are multiplied as
// signed values. Stages 2..NUM_STAGE-1 carry the product and sidebands.
// Stage NUM_STAGE is the accumulator/output register.
// ce=0 freezes every register. A valid beat reaches the outputs NUM_STAGE-1
// ce-qualified edges after the edge that sampled it.
//
// Ports:
//   ap_clk     in   clock, rising edge
//   ap_rst_n   in   asynchronous reset, active-low
//   ce         in   clock enable for all registers
//   in_valid   in   din0/din1/acc_en/acc_clr valid this cycle
//   din0       in   operand A, DIN0_WIDTH bits (signedness set by DIN0_SIGNED)
//   din1       in   operand B, DIN1_WIDTH bits (signedness set by DIN1_SIGNED)
//   acc_en     in   1 = accumulate this beat, 0 = pass the product through
//   acc_clr    in   with acc_en: this beat starts a new sum
//   out_valid  out  dout holds a new result
//   dout       out  signed result (product or running sum), ACC_WIDTH bits
//   ovf        out  the result on this beat was saturated
module myproject_mac_pipe #(
  parameter int ID          = 1,
  parameter int DIN0_WIDTH  = 6,
  parameter int DIN1_WIDTH  = 6,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 1,
  parameter int NUM_STAGE   = 2,
  parameter int ACC_WIDTH   = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        ce,
  input  logic                        in_valid,
  input  logic [DIN0_WIDTH-1:0]       din0,
  input  logic [DIN1_WIDTH-1:0]       din1,
  input  logic                        acc_en,
  input  logic                        acc_clr,
  output logic                        out_valid,
  output logic signed [ACC_WIDTH-1:0] dout,
  output logic                        ovf
);

  // The full product of the two extended operands. It is wider than
  // DIN0_WIDTH+DIN1_WIDTH so the unsigned*unsigned case stays exact.
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 2;
  localparam int MW = (ACC_WIDTH > PW) ? ACC_WIDTH : PW;
  localparam int NM = NUM_STAGE - 2;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  if (NUM_STAGE < 2 || NUM_STAGE > 6 || ACC_WIDTH < DIN0_WIDTH + DIN1_WIDTH + 1 || ID < 0)
  begin : g_bad_param
    $error("myproject_mac_pipe: illegal parameter combination");
  end

  // Extend operand A by one bit according to its signedness, then widen to MW.
  function automatic logic signed [MW-1:0] ext0(input logic [DIN0_WIDTH-1:0] x);
    logic signed [DIN0_WIDTH:0] e;
    e = (DIN0_SIGNED != 0) ? {x[DIN0_WIDTH-1], x} : {1'b0, x};
    return MW'(e);
  endfunction

  // Extend operand B by one bit according to its signedness, then widen to MW.
  function automatic logic signed [MW-1:0] ext1(input logic [DIN1_WIDTH-1:0] x);
    logic signed [DIN1_WIDTH:0] e;
    e = (DIN1_SIGNED != 0) ? {x[DIN1_WIDTH-1], x} : {1'b0, x};
    return MW'(e);
  endfunction

  logic [DIN0_WIDTH-1:0]        a_r;
  logic [DIN1_WIDTH-1:0]        b_r;
  logic                         v1_r, en1_r, clr1_r;
  logic signed [MW-1:0]         prod_full_s;
  logic signed [ACC_WIDTH-1:0]  prod_s;
  logic signed [ACC_WIDTH-1:0]  fin_p_s;
  logic                         fin_v_s, fin_en_s, fin_clr_s;
  logic signed [ACC_WIDTH:0]    sum_s;
  logic signed [ACC_WIDTH-1:0]  nxt_dout_s;
  logic                         nxt_valid_s, nxt_ovf_s;
  logic signed [ACC_WIDTH-1:0]  dout_r;
  logic                         out_valid_r, ovf_r;

  // Stage 1: register the operands and sidebands.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      v1_r   <= 1'b0;
      en1_r  <= 1'b0;
      clr1_r <= 1'b0;
    end else if (ce) begin
      a_r    <= din0;
      b_r    <= din1;
      v1_r   <= in_valid;
      en1_r  <= acc_en;
      clr1_r <= acc_clr;
    end
  end

  // Exact signed product. It is truncated to ACC_WIDTH, which is lossless
  // because ACC_WIDTH >= DIN0_WIDTH+DIN1_WIDTH+1.
  assign prod_full_s = ext0(a_r) * ext1(b_r);
  assign prod_s      = $signed(prod_full_s[ACC_WIDTH-1:0]);

  if (NM == 0) begin : g_direct
    assign fin_p_s   = prod_s;
    assign fin_v_s   = v1_r;
    assign fin_en_s  = en1_r;
    assign fin_clr_s = clr1_r;
  end else begin : g_mid
    logic signed [ACC_WIDTH-1:0] p_r [NM];
    logic [NM-1:0]               v_r, en_r, clr_r;

    // Middle stages: shift the product and sidebands towards the accumulator.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int i = 0; i < NM; i++) p_r[i] <= '0;
        v_r   <= '0;
        en_r  <= '0;
        clr_r <= '0;
      end else if (ce) begin
        p_r[0]   <= prod_s;
        v_r[0]   <= v1_r;
        en_r[0]  <= en1_r;
        clr_r[0] <= clr1_r;
        for (int i = 1; i < NM; i++) begin
          p_r[i]   <= p_r[i-1];
          v_r[i]   <= v_r[i-1];
          en_r[i]  <= en_r[i-1];
          clr_r[i] <= clr_r[i-1];
        end
      end
    end

    assign fin_p_s   = p_r[NM-1];
    assign fin_v_s   = v_r[NM-1];
    assign fin_en_s  = en_r[NM-1];
    assign fin_clr_s = clr_r[NM-1];
  end

  // Final stage next-state: pass the product, or add it to the sum with
  // saturation. A bubble keeps the sum and drops valid and ovf.
  always_comb begin
    sum_s       = {dout_r[ACC_WIDTH-1], dout_r} + {fin_p_s[ACC_WIDTH-1], fin_p_s};
    nxt_dout_s  = dout_r;
    nxt_valid_s = 1'b0;
    nxt_ovf_s   = 1'b0;
    if (fin_v_s) begin
      nxt_valid_s = 1'b1;
      if (fin_en_s && !fin_clr_s) begin
        // The top two bits of the ACC_WIDTH+1 sum differ only on overflow.
        if (sum_s[ACC_WIDTH] != sum_s[ACC_WIDTH-1]) begin
          nxt_ovf_s  = 1'b1;
          nxt_dout_s = sum_s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
          nxt_dout_s = $signed(sum_s[ACC_WIDTH-1:0]);
        end
      end else begin
        nxt_dout_s = fin_p_s;
      end
    end else begin
      nxt_dout_s = dout_r;
    end
  end

  // Final stage: accumulator/output register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_r      <= '0;
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (ce) begin
      dout_r      <= nxt_dout_s;
      out_valid_r <= nxt_valid_s;
      ovf_r       <= nxt_ovf_s;
    end
  end

  assign dout      = dout_r;
  assign out_valid = out_valid_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Directed bench for myproject_mac_pipe. Three instances share one stimulus:
// u_def uses the defaults (din0 unsigned, din1 signed, 2 stages), u_ss has
// both operands signed with 3 stages, and u_uu has both unsigned with 3 stages.
module tb_myproject_mac_pipe;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        ce;
  logic        in_valid;
  logic [5:0]  din0;
  logic [5:0]  din1;
  logic        acc_en;
  logic        acc_clr;

  logic        v_d, ovf_d, v_s, ovf_s, v_u, ovf_u;
  logic signed [15:0] dout_d, dout_s, dout_u;

  int total = 0;
  int bad   = 0;

  myproject_mac_pipe u_def (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(v_d), .dout(dout_d), .ovf(ovf_d)
  );

  myproject_mac_pipe #(.DIN0_SIGNED(1), .DIN1_SIGNED(1), .NUM_STAGE(3)) u_ss (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(v_s), .dout(dout_s), .ovf(ovf_s)
  );

  myproject_mac_pipe #(.DIN0_SIGNED(0), .DIN1_SIGNED(0), .NUM_STAGE(3)) u_uu (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid),
    .din0(din0), .din1(din1), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(v_u), .dout(dout_u), .ovf(ovf_u)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] a, input logic [5:0] b,
                       input logic en, input logic clr);
    in_valid = v;
    din0     = a;
    din1     = b;
    acc_en   = en;
    acc_clr  = clr;
  endtask

  initial begin
    int   p;
    logic o;
    ce = 1'b1;
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    ap_rst_n = 1'b1;
    #2 ap_rst_n = 1'b0;
    #1;
    chk("rst_dout", 32'(dout_d), 32'sd0);
    chk("rst_valid", 32'(v_d), 32'sd0);
    chk("rst_ovf", 32'(ovf_d), 32'sd0);
    step();
    step();
    ap_rst_n = 1'b1;

    // Defaults: 63 * -32
    drive(1'b1, 6'd63, 6'h20, 1'b0, 1'b0);
    step();
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    step();
    chk("def_valid", 32'(v_d), 32'sd1);
    chk("def_dout", 32'(dout_d), -32'sd2016);
    chk("def_ovf", 32'(ovf_d), 32'sd0);
    step();
    chk("def_bubble_valid", 32'(v_d), 32'sd0);
    chk("def_bubble_dout", 32'(dout_d), -32'sd2016);
    chk("ss_m1x_m32", 32'(dout_s), 32'sd32);
    chk("uu_63x32", 32'(dout_u), 32'sd2016);
    chk("ss_valid_lat3", 32'(v_s), 32'sd1);

    // Signed*signed corner and unsigned*unsigned maximum, 3 stages
    drive(1'b1, 6'h20, 6'h20, 1'b0, 1'b0);
    step();
    drive(1'b1, 6'd63, 6'd63, 1'b0, 1'b0);
    step();
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    step();
    chk("ss_m32xm32", 32'(dout_s), 32'sd1024);
    chk("uu_32x32", 32'(dout_u), 32'sd1024);
    step();
    chk("ss_m1xm1", 32'(dout_s), 32'sd1);
    chk("uu_63x63", 32'(dout_u), 32'sd3969);
    chk("uu_ovf", 32'(ovf_u), 32'sd0);
    step();
    chk("ss_idle_valid", 32'(v_s), 32'sd0);

    // Accumulate on the defaults: 3*4, +5*6, +10*-1
    drive(1'b1, 6'd3, 6'd4, 1'b1, 1'b1);
    step();
    drive(1'b1, 6'd5, 6'd6, 1'b1, 1'b0);
    step();
    chk("acc1_dout", 32'(dout_d), 32'sd12);
    chk("acc1_valid", 32'(v_d), 32'sd1);
    drive(1'b1, 6'd10, 6'h3F, 1'b1, 1'b0);
    step();
    chk("acc2_dout", 32'(dout_d), 32'sd42);
    chk("acc2_valid", 32'(v_d), 32'sd1);
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    step();
    chk("acc3_dout", 32'(dout_d), 32'sd32);
    chk("acc3_valid", 32'(v_d), 32'sd1);
    step();
    chk("acc_hold_dout", 32'(dout_d), 32'sd32);
    chk("acc_hold_valid", 32'(v_d), 32'sd0);

    // Saturation: 63*31 = 1953 per beat, 18 beats
    for (int i = 1; i <= 18; i++) begin
      drive(1'b1, 6'd63, 6'd31, 1'b1, (i == 1));
      step();
      if (i >= 2) begin
        p = (i - 1) * 1953;
        o = (p > 32767);
        if (o) p = 32767;
        chk("sat_dout", 32'(dout_d), p);
        chk("sat_ovf", 32'(ovf_d), 32'(o));
      end
    end
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    step();
    chk("sat18_dout", 32'(dout_d), 32'sd32767);
    chk("sat18_ovf", 32'(ovf_d), 32'sd1);
    repeat (3) step();
    chk("flush_valid", 32'(v_s), 32'sd0);

    // Stall on the 3-stage signed instance: 2*3 with clr, then 4 ce=0 cycles
    drive(1'b1, 6'd2, 6'd3, 1'b1, 1'b1);
    step();
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    ce = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_novalid", 32'(v_s), 32'sd0);
    end
    ce = 1'b1;
    step();
    chk("stall_mid_valid", 32'(v_s), 32'sd0);
    step();
    chk("stall_valid", 32'(v_s), 32'sd1);
    chk("stall_dout", 32'(dout_s), 32'sd6);
    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("frozen_valid", 32'(v_s), 32'sd1);
      chk("frozen_dout", 32'(dout_s), 32'sd6);
    end
    ce = 1'b1;
    drive(1'b1, 6'd1, 6'd1, 1'b1, 1'b0);
    step();
    chk("post_stall_bubble_valid", 32'(v_s), 32'sd0);
    chk("post_stall_bubble_dout", 32'(dout_s), 32'sd6);
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    step();
    step();
    chk("post_stall_acc", 32'(dout_s), 32'sd7);
    chk("post_stall_acc_valid", 32'(v_s), 32'sd1);

    // Asynchronous reset with two beats in flight
    drive(1'b1, 6'd2, 6'd2, 1'b1, 1'b0);
    step();
    drive(1'b1, 6'd3, 6'd3, 1'b1, 1'b0);
    step();
    drive(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("arst_dout_s", 32'(dout_s), 32'sd0);
    chk("arst_valid_s", 32'(v_s), 32'sd0);
    chk("arst_ovf_s", 32'(ovf_s), 32'sd0);
    chk("arst_dout_d", 32'(dout_d), 32'sd0);
    chk("arst_valid_d", 32'(v_d), 32'sd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_stale_valid_s", 32'(v_s), 32'sd0);
      chk("no_stale_valid_d", 32'(v_d), 32'sd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
